// File: rtl/div_restoring.sv
// Sequential signed restoring divider: q = a / b, r = a % b, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), start, a, b in; q, r, done, busy, dbz, ovf out.
module div_restoring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             busy,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX
  } state_t;

  state_t state, nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sa;
  logic             sb;
  logic             z;
  logic             ov;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH+1:0] shl;
  logic [WIDTH+1:0] dvs_x;
  logic             ge;

  // |min| = 2^(WIDTH-1) is representable as an unsigned WIDTH-bit value.
  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    shl   = {rem, quo[WIDTH-1]};
    dvs_x = {2'b00, dvs};
    ge    = shl >= dvs_x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = DIV;
      DIV:  if (cnt == CW'(1)) nxt = FIX;
      FIX:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      z    <= 1'b0;
      ov   <= 1'b0;
      q    <= '0;
      r    <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rem  <= '0;
            quo  <= a_mag;
            dvs  <= b_mag;
            sa   <= a[WIDTH-1];
            sb   <= b[WIDTH-1];
            z    <= (b == '0);
            ov   <= (a == MIN_V) && (b == '1);
            cnt  <= CW'(WIDTH);
            busy <= 1'b1;
          end
        end
        DIV: begin
          rem <= ge ? (WIDTH+1)'(shl - dvs_x)
                    : (WIDTH+1)'(shl);
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          // With a zero divisor every step subtracts nothing, so the
          // remainder ends as |a| and the sign fix below yields r = a.
          if (z) begin
            q <= '1;
          end else begin
            q <= (sa ^ sb) ? -quo : quo;
          end
          r    <= sa ? WIDTH'(-rem) : WIDTH'(rem);
          done <= 1'b1;
          busy <= 1'b0;
          dbz  <= z;
          ovf  <= ov;
        end
        default: ;
      endcase
    end
  end

endmodule
